pipe_ctrl_hazard: RTL and testbench
===================================

// Module: pipe_ctrl_hazard
// PURPOSE
//  Pipelined control unit for the 5-stage no-forwarding MIPS core.
//  - Decodes the ID-stage opcode into the 18-bit control bundle.
//  - Carries the bundle and destination register through the EX, MEM and WB stages.
//  - Detects RAW hazards against in-flight writers and stalls ID until the hazard clears.
//  - Turns ID-stage instructions into bubbles on flush.
// PARAMETERS
//  REG_AW     5  register address width
//  HAZ_DEPTH  3  in-flight stages checked for RAW (3: EX/MEM/WB; 2: regfile write-through); range 1..3
// PORTS
//  clk        in   1       clock
//  rst        in   1       synchronous reset, active high
//  id_valid   in   1       ID holds a real instruction
//  id_op      in   6       ID opcode [31:26]
//  id_rs      in   REG_AW  ID rs field
//  id_rt      in   REG_AW  ID rt field
//  id_rd      in   REG_AW  ID rd field
//  flush      in   1       branch/jump taken; kill ID instruction
//  freeze     in   1       global hold (memory wait); all stage registers hold
//  stall      out  1       hold PC and IF/ID; combinational
//  illegal    out  1       id_valid and opcode not in decode table; combinational
//  ex_ctrl    out  18      EX-stage bundle; registered
//  mem_ctrl   out  18      MEM-stage bundle; registered
//  wb_ctrl    out  18      WB-stage bundle; registered
//  ex_dst     out  REG_AW  EX-stage destination register
//  mem_dst    out  REG_AW  MEM-stage destination register
//  wb_dst     out  REG_AW  WB-stage destination register
//  stall_cnt  out  16      [PIPE_CTRL_STATS_EN only] stall cycles, saturating
//  flush_cnt  out  16      [PIPE_CTRL_STATS_EN only] flushes, saturating
// BEHAVIOUR
//  Bundle layout, MSB to LSB (18 bits):
//    Branch[2] Jump[2] RegDst ALUSrc ALUOp[4] MemtoReg RegWrite MemWrite[2] ExtOp MemRead[3]
//  Encodings:
//    ALUOp: ADD=0, RType=1, OR=2, AND=3, SUB=4, XOR=5, SLT=6, SLTU=7, LUI=8
//    MemWrite: none=0, sh=1, sb=2, sw=3
//    MemRead: lw=0, lh=1, lhu=2, lb=3, lbu=4
//    Branch: none=0, beq=1, bne=2
//    Jump: none=0, j=1, jal=2
//  Decoded opcodes: R, addi, addiu, andi, ori, xori, slti, sltiu, lui, lw, lh, lhu, lb, lbu,
//    sw, sh, sb, beq, bne, j, jal. Any other opcode -> all-zero bundle (NOP) and illegal=1.
//  Destination:
//    R-type -> rd; jal -> 31; other RegWrite ops -> rt.
//    RegWrite=0 or dst=0 -> no write tracked.
//  Source use:
//    rs is read by all ops except j, jal, lui.
//    rt is read by R-type, beq, bne, sw, sh, sb.
//  RAW hazard: a used, nonzero source equals a tracked dst in any of the first HAZ_DEPTH
//    of EX/MEM/WB.
//  stall = id_valid & hazard & ~flush & ~rst.
//  Each edge, in priority order:
//    1. rst: all bundles and dsts = 0; counters = 0.
//    2. freeze: all stage registers hold. stall is still reported; the pipeline does not advance.
//    3. Otherwise advance WB<=MEM, MEM<=EX. EX loads a bubble (bundle 0, dst 0) if
//       flush | stall | ~id_valid | illegal; otherwise it loads the decoded bundle and dst.
//  Latency: an accepted instruction's bundle appears on ex_ctrl 1 cycle later, mem_ctrl 2 later,
//    wb_ctrl 3 later.
//  Stall length: HAZ_DEPTH minus the hazard distance, plus 1. A back-to-back dependency with
//    HAZ_DEPTH=3 stalls 3 cycles.
//  flush and hazard together: flush wins; stall=0 that cycle.
//  Reset mid-stall: stall drops combinationally while rst=1; the pipeline is empty afterwards.
// CONFIGURATION
//  PIPE_CTRL_STATS_EN defined:
//    - stall_cnt increments on each non-frozen cycle with stall=1.
//    - flush_cnt increments on each cycle with flush=1.
//    - Both are 16-bit, saturate at 0xFFFF, and clear on rst.
//  PIPE_CTRL_STATS_EN undefined: the counter ports and logic are absent.
// TESTING
//  1. addu r3 then addu r4,r3,r1 back-to-back, HAZ_DEPTH=3 -> stall=1 for 3 cycles; 3 zero
//     bundles on ex_ctrl; then ex_ctrl=RType bundle, ex_dst=4.
//  2. lw r2; independent op; sw r2 -> stall 2 cycles. When lw reaches WB: wb_ctrl MemtoReg=1,
//     RegWrite=1, MemRead=0, wb_dst=2.
//  3. ori r0 then addu r5,r0,r0 -> stall never asserts. jal then jr-style rs=31 -> stall 3 cycles.
//  4. flush asserted during a hazard stall -> stall=0 that cycle; ex_ctrl=0 next cycle;
//     flush_cnt +1.
//  5. freeze=1 for 4 cycles during a stall -> ex/mem/wb outputs constant. stall_cnt unchanged.
//  6. rst mid-pipeline; opcode 6'b111111 -> all outputs 0 after the edge; illegal=1; bubble
//     injected; no stall.

Source files
------------

// File: rtl/pipe_ctrl_hazard.sv
// Pipelined control unit for the 5-stage no-forwarding MIPS core: decode, EX/MEM/WB bundle carry, RAW stall, flush bubbles.
// Optional stall/flush statistics counters are built when PIPE_CTRL_STATS_EN is defined.
module pipe_ctrl_hazard #(
  parameter int REG_AW    = 5,
  parameter int HAZ_DEPTH = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [5:0]        id_op,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              flush,
  input  logic              freeze,
  output logic              stall,
  output logic              illegal,
  output logic [17:0]       ex_ctrl,
  output logic [17:0]       mem_ctrl,
  output logic [17:0]       wb_ctrl,
  output logic [REG_AW-1:0] ex_dst,
  output logic [REG_AW-1:0] mem_dst,
  output logic [REG_AW-1:0] wb_dst
`ifdef PIPE_CTRL_STATS_EN
  ,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       flush_cnt
`endif
);

  localparam logic [5:0] OP_R     = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;

  logic [1:0]        br, jmp, mw;
  logic              reg_dst, alu_src, m2r, rw, ext;
  logic [3:0]        alu_op;
  logic [2:0]        mr;
  logic              use_rs, use_rt, legal;
  logic [17:0]       dec_ctrl;
  logic [REG_AW-1:0] dec_dst;
  logic [REG_AW-1:0] stg_dst [3];
  logic              hazard, load_bubble;

  logic [17:0]       ex_ctrl_q, mem_ctrl_q, wb_ctrl_q;
  logic [REG_AW-1:0] ex_dst_q, mem_dst_q, wb_dst_q;
  logic [17:0]       ex_ctrl_d;
  logic [REG_AW-1:0] ex_dst_d;

  always_comb begin
    br = 2'd0; jmp = 2'd0; reg_dst = 1'b0; alu_src = 1'b0; alu_op = 4'd0;
    m2r = 1'b0; rw = 1'b0; mw = 2'd0; ext = 1'b0; mr = 3'd0;
    use_rs = 1'b1; use_rt = 1'b0; legal = 1'b1;
    case (id_op)
      OP_R:     begin reg_dst = 1'b1; alu_op = 4'd1; rw = 1'b1; use_rt = 1'b1; end
      OP_ADDI,
      OP_ADDIU: begin alu_src = 1'b1; alu_op = 4'd0; rw = 1'b1; ext = 1'b1; end
      OP_ANDI:  begin alu_src = 1'b1; alu_op = 4'd3; rw = 1'b1; end
      OP_ORI:   begin alu_src = 1'b1; alu_op = 4'd2; rw = 1'b1; end
      OP_XORI:  begin alu_src = 1'b1; alu_op = 4'd5; rw = 1'b1; end
      OP_SLTI:  begin alu_src = 1'b1; alu_op = 4'd6; rw = 1'b1; ext = 1'b1; end
      OP_SLTIU: begin alu_src = 1'b1; alu_op = 4'd7; rw = 1'b1; ext = 1'b1; end
      OP_LUI:   begin alu_src = 1'b1; alu_op = 4'd8; rw = 1'b1; use_rs = 1'b0; end
      OP_LW:    begin alu_src = 1'b1; m2r = 1'b1; rw = 1'b1; ext = 1'b1; mr = 3'd0; end
      OP_LH:    begin alu_src = 1'b1; m2r = 1'b1; rw = 1'b1; ext = 1'b1; mr = 3'd1; end
      OP_LHU:   begin alu_src = 1'b1; m2r = 1'b1; rw = 1'b1; ext = 1'b1; mr = 3'd2; end
      OP_LB:    begin alu_src = 1'b1; m2r = 1'b1; rw = 1'b1; ext = 1'b1; mr = 3'd3; end
      OP_LBU:   begin alu_src = 1'b1; m2r = 1'b1; rw = 1'b1; ext = 1'b1; mr = 3'd4; end
      OP_SH:    begin alu_src = 1'b1; mw = 2'd1; ext = 1'b1; use_rt = 1'b1; end
      OP_SB:    begin alu_src = 1'b1; mw = 2'd2; ext = 1'b1; use_rt = 1'b1; end
      OP_SW:    begin alu_src = 1'b1; mw = 2'd3; ext = 1'b1; use_rt = 1'b1; end
      OP_BEQ:   begin br = 2'd1; alu_op = 4'd4; ext = 1'b1; use_rt = 1'b1; end
      OP_BNE:   begin br = 2'd2; alu_op = 4'd4; ext = 1'b1; use_rt = 1'b1; end
      OP_J:     begin jmp = 2'd1; use_rs = 1'b0; end
      OP_JAL:   begin jmp = 2'd2; rw = 1'b1; use_rs = 1'b0; end
      default:  begin legal = 1'b0; use_rs = 1'b0; end
    endcase
    dec_ctrl = {br, jmp, reg_dst, alu_src, alu_op, m2r, rw, mw, ext, mr};
  end

  // A zero destination doubles as "no write tracked" for the hazard compare.
  always_comb begin
    dec_dst = '0;
    if (rw) begin
      if (id_op == OP_R)        dec_dst = id_rd;
      else if (id_op == OP_JAL) dec_dst = REG_AW'(31);
      else                      dec_dst = id_rt;
    end
  end

  always_comb begin
    stg_dst[0] = ex_dst_q;
    stg_dst[1] = mem_dst_q;
    stg_dst[2] = wb_dst_q;
    hazard = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k < HAZ_DEPTH && stg_dst[k] != '0 &&
          ((use_rs && id_rs == stg_dst[k]) || (use_rt && id_rt == stg_dst[k])))
        hazard = 1'b1;
    end
  end

  assign illegal     = id_valid & ~legal;
  assign stall       = id_valid & hazard & ~flush & ~rst;
  assign load_bubble = flush | stall | ~id_valid | ~legal;
  assign ex_ctrl_d   = load_bubble ? 18'd0 : dec_ctrl;
  assign ex_dst_d    = load_bubble ? '0 : dec_dst;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_ctrl_q  <= '0;
      mem_ctrl_q <= '0;
      wb_ctrl_q  <= '0;
      ex_dst_q   <= '0;
      mem_dst_q  <= '0;
      wb_dst_q   <= '0;
    end else if (!freeze) begin
      wb_ctrl_q  <= mem_ctrl_q;
      wb_dst_q   <= mem_dst_q;
      mem_ctrl_q <= ex_ctrl_q;
      mem_dst_q  <= ex_dst_q;
      ex_ctrl_q  <= ex_ctrl_d;
      ex_dst_q   <= ex_dst_d;
    end
  end

  assign ex_ctrl  = ex_ctrl_q;
  assign mem_ctrl = mem_ctrl_q;
  assign wb_ctrl  = wb_ctrl_q;
  assign ex_dst   = ex_dst_q;
  assign mem_dst  = mem_dst_q;
  assign wb_dst   = wb_dst_q;

`ifdef PIPE_CTRL_STATS_EN
  logic [15:0] stall_cnt_q, flush_cnt_q;

  // Frozen stall cycles are not counted: the hold there is the memory's, not the hazard's.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall && !freeze && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
      if (flush && flush_cnt_q != 16'hFFFF)             flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl_hazard.sv
// Directed bench for pipe_ctrl_hazard: driver pushes hand-computed expectations, a monitor pops and compares each cycle.
module tb_pipe_ctrl_hazard;

  localparam int AW = 5;
  localparam int W  = 71;

  localparam logic [17:0] C_RT    = 18'h02140;
  localparam logic [17:0] C_ORI   = 18'h01240;
  localparam logic [17:0] C_LW    = 18'h010C8;
  localparam logic [17:0] C_SW    = 18'h01038;
  localparam logic [17:0] C_JAL   = 18'h08040;
  localparam logic [17:0] C_ADDIU = 18'h01048;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          id_valid = 1'b0;
  logic [5:0]    id_op = '0;
  logic [AW-1:0] id_rs = '0, id_rt = '0, id_rd = '0;
  logic          flush = 1'b0, freeze = 1'b0;
  logic          stall, illegal;
  logic [17:0]   ex_ctrl, mem_ctrl, wb_ctrl;
  logic [AW-1:0] ex_dst, mem_dst, wb_dst;
`ifdef PIPE_CTRL_STATS_EN
  logic [15:0]   stall_cnt, flush_cnt;
`endif

  pipe_ctrl_hazard #(.REG_AW(AW), .HAZ_DEPTH(3)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_op(id_op),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .flush(flush), .freeze(freeze),
    .stall(stall), .illegal(illegal),
    .ex_ctrl(ex_ctrl), .mem_ctrl(mem_ctrl), .wb_ctrl(wb_ctrl),
    .ex_dst(ex_dst), .mem_dst(mem_dst), .wb_dst(wb_dst)
`ifdef PIPE_CTRL_STATS_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  logic [W-1:0]  exp_q[$];
  int            total = 0;
  int            bad = 0;

  logic [17:0]   m_ex_c = '0, m_mem_c = '0, m_wb_c = '0;
  logic [AW-1:0] m_ex_d = '0, m_mem_d = '0, m_wb_d = '0;
  int            m_sc = 0, m_fc = 0;

  task automatic check(input string name, input logic [17:0] act, input logic [17:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
    end
  endtask

  // driver: one cycle of ID inputs plus the expected stall/illegal now and stage contents after the edge
  task automatic step(input logic r, input logic v, input logic [5:0] op,
                      input logic [AW-1:0] rs, input logic [AW-1:0] rt, input logic [AW-1:0] rd,
                      input logic fl, input logic fz, input logic es, input logic ei,
                      input logic [17:0] ec, input logic [AW-1:0] ed);
    @(negedge clk);
    rst = r; id_valid = v; id_op = op; id_rs = rs; id_rt = rt; id_rd = rd;
    flush = fl; freeze = fz;
    if (r) begin
      m_ex_c = '0; m_mem_c = '0; m_wb_c = '0;
      m_ex_d = '0; m_mem_d = '0; m_wb_d = '0;
      m_sc = 0; m_fc = 0;
    end else begin
      if (!fz) begin
        m_wb_c = m_mem_c; m_wb_d = m_mem_d;
        m_mem_c = m_ex_c; m_mem_d = m_ex_d;
        m_ex_c = ec;      m_ex_d = ed;
      end
      if (fl) m_fc++;
      if (es && !fz) m_sc++;
    end
    exp_q.push_back({es, ei, m_ex_c, m_ex_d, m_mem_c, m_mem_d, m_wb_c, m_wb_d});
  endtask

  task automatic idle();
    step(0, 0, 6'h00, 0, 0, 0, 0, 0, 0, 0, 18'd0, 0);
  endtask

  task automatic check_cnt();
`ifdef PIPE_CTRL_STATS_EN
    @(negedge clk);
    check("stall_cnt", {2'b0, stall_cnt}, 18'(m_sc));
    check("flush_cnt", {2'b0, flush_cnt}, 18'(m_fc));
`endif
  endtask

  // scoreboard monitor: combinational outputs sampled late in the cycle, registered ones just after the edge
  initial begin : monitor
    logic [W-1:0] e;
    logic s_stall, s_ill;
    forever begin
      @(negedge clk);
      #3;
      s_stall = stall;
      s_ill   = illegal;
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("stall",    {17'd0, s_stall}, {17'd0, e[70]});
        check("illegal",  {17'd0, s_ill},   {17'd0, e[69]});
        check("ex_ctrl",  ex_ctrl,          e[68:51]);
        check("ex_dst",   {13'd0, ex_dst},  {13'd0, e[50:46]});
        check("mem_ctrl", mem_ctrl,         e[45:28]);
        check("mem_dst",  {13'd0, mem_dst}, {13'd0, e[27:23]});
        check("wb_ctrl",  wb_ctrl,          e[22:5]);
        check("wb_dst",   {13'd0, wb_dst},  {13'd0, e[4:0]});
      end
    end
  end

  initial begin : stimulus
    // reset state
    step(1, 0, 6'h00, 0, 0, 0, 0, 0, 0, 0, 18'd0, 0);
    step(1, 0, 6'h00, 0, 0, 0, 0, 0, 0, 0, 18'd0, 0);

    // addu r3,r1,r2 ; addu r4,r3,r1 back-to-back: three stall cycles
    step(0, 1, 6'h00, 1, 2, 3, 0, 0, 0, 0, C_RT, 3);
    step(0, 1, 6'h00, 3, 1, 4, 0, 0, 1, 0, 18'd0, 0);
    step(0, 1, 6'h00, 3, 1, 4, 0, 0, 1, 0, 18'd0, 0);
    step(0, 1, 6'h00, 3, 1, 4, 0, 0, 1, 0, 18'd0, 0);
    step(0, 1, 6'h00, 3, 1, 4, 0, 0, 0, 0, C_RT, 4);
    repeat (3) idle();

    // lw r2 ; addiu r6,r7 ; sw r2: two stall cycles, lw visible in WB
    step(0, 1, 6'h23, 1, 2, 0, 0, 0, 0, 0, C_LW, 2);
    step(0, 1, 6'h09, 7, 6, 0, 0, 0, 0, 0, C_ADDIU, 6);
    step(0, 1, 6'h2B, 1, 2, 0, 0, 0, 1, 0, 18'd0, 0);
    step(0, 1, 6'h2B, 1, 2, 0, 0, 0, 1, 0, 18'd0, 0);
    step(0, 1, 6'h2B, 1, 2, 0, 0, 0, 0, 0, C_SW, 0);
    repeat (3) idle();

    // ori r0 ; addu r5,r0,r0: no stall. jal ; jr r31: three stall cycles
    step(0, 1, 6'h0D, 1, 0, 0, 0, 0, 0, 0, C_ORI, 0);
    step(0, 1, 6'h00, 0, 0, 5, 0, 0, 0, 0, C_RT, 5);
    step(0, 1, 6'h03, 0, 0, 0, 0, 0, 0, 0, C_JAL, 31);
    step(0, 1, 6'h00, 31, 0, 0, 0, 0, 1, 0, 18'd0, 0);
    step(0, 1, 6'h00, 31, 0, 0, 0, 0, 1, 0, 18'd0, 0);
    step(0, 1, 6'h00, 31, 0, 0, 0, 0, 1, 0, 18'd0, 0);
    step(0, 1, 6'h00, 31, 0, 0, 0, 0, 0, 0, C_RT, 0);
    repeat (3) idle();

    // flush during a hazard stall wins
    step(0, 1, 6'h00, 1, 2, 7, 0, 0, 0, 0, C_RT, 7);
    step(0, 1, 6'h00, 7, 7, 8, 0, 0, 1, 0, 18'd0, 0);
    step(0, 1, 6'h00, 7, 7, 8, 1, 0, 0, 0, 18'd0, 0);
    repeat (3) idle();

    // freeze for 4 cycles inside a stall: everything holds
    step(0, 1, 6'h00, 1, 2, 9, 0, 0, 0, 0, C_RT, 9);
    step(0, 1, 6'h00, 9, 1, 10, 0, 0, 1, 0, 18'd0, 0);
    repeat (4) step(0, 1, 6'h00, 9, 1, 10, 0, 1, 1, 0, 18'd0, 0);
    step(0, 1, 6'h00, 9, 1, 10, 0, 0, 1, 0, 18'd0, 0);
    step(0, 1, 6'h00, 9, 1, 10, 0, 0, 1, 0, 18'd0, 0);
    step(0, 1, 6'h00, 9, 1, 10, 0, 0, 0, 0, C_RT, 10);
    check_cnt();

    // reset mid-pipeline with a pending hazard, then an illegal opcode
    step(0, 1, 6'h00, 1, 2, 11, 0, 0, 0, 0, C_RT, 11);
    step(1, 1, 6'h00, 11, 1, 12, 0, 0, 0, 0, 18'd0, 0);
    step(0, 1, 6'h3F, 11, 11, 12, 0, 0, 0, 1, 18'd0, 0);
    step(0, 1, 6'h00, 1, 2, 13, 0, 0, 0, 0, C_RT, 13);
    repeat (3) idle();
    check_cnt();

    // bounded drain of the scoreboard
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
